dark_channel_estimator: RTL
===========================

DARK_CHANNEL_ESTIMATOR -- requirements
Module: dark_channel_estimator

Interface
REQ-001 SHALL have parameter WIN_COUNT, default 262144, meaning the number of valid 3x3 windows per frame.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIN_COUNT), meaning the width of the window-beat counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports input_pixel_1..input_pixel_9, input, 24 bits each: 3x3 window, row-major, with input_pixel_5 the centre; each pixel packs R[23:16], G[15:8], B[7:0].
REQ-006 SHALL have port input_is_valid, input, 1 bit: the window is valid this cycle; there is no backpressure.
REQ-007 SHALL have port dark_pixel, output, 8 bits: dark-channel value of the window.
REQ-008 SHALL have port center_pixel, output, 24 bits: input_pixel_5, delay-matched to dark_pixel.
REQ-009 SHALL have port output_is_valid, output, 1 bit: qualifies dark_pixel and center_pixel.
REQ-010 SHALL have port atm_light, output, 24 bits: atmospheric-light RGB estimate of the last completed frame.
REQ-011 SHALL have port atm_light_valid, output, 1 bit: one-cycle pulse when atm_light updates.

Function
REQ-012 Stage 1 SHALL register, per window pixel k, cmin_k = min(R,G,B) with 8-bit unsigned compares, together with valid and the centre pixel.
REQ-013 Stage 2 SHALL register three row minima: min(cmin_1..3), min(cmin_4..6), min(cmin_7..9).
REQ-014 Stage 3 SHALL register dark_pixel = min of the three row minima, plus center_pixel and output_is_valid.
REQ-015 Latency SHALL be exactly 3 cycles from input_is_valid to output_is_valid, with full throughput of one window per cycle.
REQ-016 Invalid cycles SHALL propagate as bubbles; data registers MAY hold stale values while valid is 0.
REQ-017 The atmospheric-light tracker SHALL hold max_dark (8 bits), cand_rgb (24 bits) and beat_cnt (CNT_W bits).
REQ-018 On each output_is_valid beat, the tracker SHALL set max_dark <= dark_pixel and cand_rgb <= center_pixel when dark_pixel > max_dark (strict compare).
REQ-019 On a tie, the tracker SHALL keep the earlier candidate.
REQ-020 beat_cnt SHALL increment on each output_is_valid beat.
REQ-021 On the beat where beat_cnt == WIN_COUNT-1, the tracker SHALL:
  - publish the next cycle: atm_light <= the winner including this beat's candidate, and atm_light_valid = 1 for exactly one cycle;
  - clear beat_cnt, max_dark and cand_rgb to 0 on the same edge, so the following beat starts a fresh frame.
REQ-022 If the first beat of a new frame arrives in the cycle immediately after the last beat, it SHALL be compared against the cleared state (max_dark = 0) and SHALL NOT be lost.
REQ-023 A frame whose best dark_pixel is 0 SHALL publish the centre pixel of its first beat; a first beat with dark_pixel = 0 SHALL be latched unconditionally when beat_cnt == 0.
REQ-024 atm_light SHALL hold its value between publications; atm_light_valid SHALL be 0 at all other times.
REQ-025 The block SHALL have no state-machine states beyond the counter; operation SHALL be free-running and frame boundaries SHALL be defined by count only.

Reset
REQ-026 Asserting rst SHALL clear, without waiting for a clock edge:
  - all pipeline valids, dark_pixel, center_pixel and output_is_valid;
  - atm_light, atm_light_valid, max_dark, cand_rgb and beat_cnt.
REQ-027 Reset mid-frame SHALL discard the partial frame; counting SHALL restart from 0 on the first valid after rst deasserts.
REQ-028 Windows already in flight during reset SHALL be dropped and SHALL NOT appear at the outputs.

Structure
REQ-029 Pixel width 24, channel width 8, channel bit positions and the 3-input min function SHALL live in shared package dehaze_pkg.
REQ-030 One sub-module, min3_u8 (registered 3-input 8-bit minimum), SHALL be instantiated for the row and final minima; the per-pixel channel min SHALL use the package function.

Verification
REQ-031 Reset, then one window with all nine pixels 0x80_40_C0 SHALL give dark_pixel 0x40, center_pixel 0x8040C0 and output_is_valid exactly 3 cycles later.
REQ-032 A window with all pixels 0xFFFFFF except pixel_9 = 0xFF_FF_05 SHALL give dark_pixel 0x05.
REQ-033 Streaming 10 back-to-back windows with 2 bubbles inserted SHALL produce 10 outputs, in order, each exactly 3 cycles after its input.
REQ-034 With WIN_COUNT=4 and dark values 10, 50, 50, 20 (centres A, B, C, D), atm_light SHALL equal B and atm_light_valid SHALL pulse once, the cycle after beat 4.
REQ-035 With WIN_COUNT=4, two frames back-to-back (the second with all dark 0, first centre E) SHALL publish B, then E, with the max correctly cleared between frames.
REQ-036 Asserting rst after 2 of 4 beats SHALL clear atm_light to 0; a following 4-beat frame SHALL publish only its own winner.

Source files
------------

// File: rtl/dehaze_pkg.sv
// Shared pixel/channel definitions and minimum helpers for the dehaze datapath.
package dehaze_pkg;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned CH_W  = 8;
  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_LSB = 0;

  function automatic logic [CH_W-1:0] min3(input logic [CH_W-1:0] a,
                                           input logic [CH_W-1:0] b,
                                           input logic [CH_W-1:0] c);
    logic [CH_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  // Darkest of the three colour channels of one packed RGB pixel.
  function automatic logic [CH_W-1:0] chan_min(input logic [PIX_W-1:0] pix);
    return min3(pix[R_LSB +: CH_W], pix[G_LSB +: CH_W], pix[B_LSB +: CH_W]);
  endfunction

endpackage

// File: rtl/min3_u8.sv
// Registered 3-input unsigned 8-bit minimum with load enable.
module min3_u8
  import dehaze_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [CH_W-1:0] a,
  input  logic [CH_W-1:0] b,
  input  logic [CH_W-1:0] c,
  output logic [CH_W-1:0] y
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (en) begin
      y <= min3(a, b, c);
    end
  end

endmodule

// File: rtl/dark_channel_estimator.sv
// 3-stage dark-channel pipeline over a 3x3 RGB window plus a per-frame
// atmospheric-light tracker that latches the centre pixel of the darkest-max window.
module dark_channel_estimator
  import dehaze_pkg::*;
#(
  parameter int WIN_COUNT = 262144,
  parameter int CNT_W     = $clog2(WIN_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] input_pixel_1,
  input  logic [PIX_W-1:0] input_pixel_2,
  input  logic [PIX_W-1:0] input_pixel_3,
  input  logic [PIX_W-1:0] input_pixel_4,
  input  logic [PIX_W-1:0] input_pixel_5,
  input  logic [PIX_W-1:0] input_pixel_6,
  input  logic [PIX_W-1:0] input_pixel_7,
  input  logic [PIX_W-1:0] input_pixel_8,
  input  logic [PIX_W-1:0] input_pixel_9,
  input  logic             input_is_valid,
  output logic [CH_W-1:0]  dark_pixel,
  output logic [PIX_W-1:0] center_pixel,
  output logic             output_is_valid,
  output logic [PIX_W-1:0] atm_light,
  output logic             atm_light_valid
);

  localparam int unsigned NPIX = 9;
  localparam int unsigned NROW = 3;

  logic [PIX_W-1:0] win [NPIX];

  assign win[0] = input_pixel_1;
  assign win[1] = input_pixel_2;
  assign win[2] = input_pixel_3;
  assign win[3] = input_pixel_4;
  assign win[4] = input_pixel_5;
  assign win[5] = input_pixel_6;
  assign win[6] = input_pixel_7;
  assign win[7] = input_pixel_8;
  assign win[8] = input_pixel_9;

  // Stage 1: per-pixel channel minimum.
  logic             s1_valid;
  logic [CH_W-1:0]  s1_cmin [NPIX];
  logic [PIX_W-1:0] s1_center;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_center <= '0;
      for (int unsigned k = 0; k < NPIX; k++) begin
        s1_cmin[k] <= '0;
      end
    end else begin
      s1_valid <= input_is_valid;
      if (input_is_valid) begin
        s1_center <= input_pixel_5;
        for (int unsigned k = 0; k < NPIX; k++) begin
          s1_cmin[k] <= chan_min(win[k]);
        end
      end
    end
  end

  // Stage 2: row minima.
  logic             s2_valid;
  logic [PIX_W-1:0] s2_center;
  logic [CH_W-1:0]  row_min [NROW];

  for (genvar r = 0; r < NROW; r++) begin : g_row
    min3_u8 u_row_min (
      .clk (clk),
      .rst (rst),
      .en  (s1_valid),
      .a   (s1_cmin[3*r]),
      .b   (s1_cmin[3*r+1]),
      .c   (s1_cmin[3*r+2]),
      .y   (row_min[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_center <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_center <= s1_center;
      end
    end
  end

  // Stage 3: window minimum and delay-matched centre.
  min3_u8 u_final_min (
    .clk (clk),
    .rst (rst),
    .en  (s2_valid),
    .a   (row_min[0]),
    .b   (row_min[1]),
    .c   (row_min[2]),
    .y   (dark_pixel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_is_valid <= 1'b0;
      center_pixel    <= '0;
    end else begin
      output_is_valid <= s2_valid;
      if (s2_valid) begin
        center_pixel <= s2_center;
      end
    end
  end

  // Atmospheric-light tracker: frame boundaries come from the beat count alone.
  logic [CH_W-1:0]  max_dark, max_dark_nx;
  logic [PIX_W-1:0] cand_rgb, cand_rgb_nx;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nx;
  logic [PIX_W-1:0] atm_light_nx;
  logic             atm_light_valid_nx;
  logic             take_c;
  logic             last_c;

  always_comb begin
    max_dark_nx        = max_dark;
    cand_rgb_nx        = cand_rgb;
    beat_cnt_nx        = beat_cnt;
    atm_light_nx       = atm_light;
    atm_light_valid_nx = 1'b0;
    // A frame's first beat always seeds the candidate so an all-zero frame still publishes.
    take_c = (dark_pixel > max_dark) || (beat_cnt == '0);
    last_c = (beat_cnt == CNT_W'(WIN_COUNT - 1));
    if (output_is_valid) begin
      if (last_c) begin
        atm_light_nx       = take_c ? center_pixel : cand_rgb;
        atm_light_valid_nx = 1'b1;
        beat_cnt_nx        = '0;
        max_dark_nx        = '0;
        cand_rgb_nx        = '0;
      end else begin
        beat_cnt_nx = beat_cnt + CNT_W'(1);
        if (take_c) begin
          max_dark_nx = dark_pixel;
          cand_rgb_nx = center_pixel;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_dark        <= '0;
      cand_rgb        <= '0;
      beat_cnt        <= '0;
      atm_light       <= '0;
      atm_light_valid <= 1'b0;
    end else begin
      max_dark        <= max_dark_nx;
      cand_rgb        <= cand_rgb_nx;
      beat_cnt        <= beat_cnt_nx;
      atm_light       <= atm_light_nx;
      atm_light_valid <= atm_light_valid_nx;
    end
  end

endmodule
